ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 device-to-host receiver with frame checking and a byte FIFO.
//  - Oversamples ps2_clk/ps2_data on a divided poll tick and deserialises 11-bit frames.
//  - Checks start, odd parity and stop bits; aborts stalled frames on timeout.
//  - Buffers good bytes in a first-word-fall-through FIFO for the keyboard/mouse
//    register interface on the system bus side.
// PARAMETERS
//  CLK_DIV   64   clk cycles per poll tick (>=2)
//  TIMEOUT   254  poll ticks of ps2_clk high mid-frame before abort (<=255)
//  FIFO_AW   3    log2 FIFO depth (depth = 2**FIFO_AW)
//  FILT_LEN  4    consecutive equal samples required by glitch filter (2..8)
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          asynchronous reset, active low
//  ps2_clk     in   1          PS/2 clock line (async, idle high)
//  ps2_data    in   1          PS/2 data line (async, idle high)
//  rd_en       in   1          pop FIFO head; honoured only while rd_valid=1
//  rd_data     out  8          FIFO head byte (valid while rd_valid=1)
//  rd_valid    out  1          FIFO not empty
//  fifo_count  out  FIFO_AW+1  bytes held, 0..2**FIFO_AW
//  parity_err  out  1          1-clk pulse: frame discarded, bad parity
//  frame_err   out  1          1-clk pulse: frame discarded, bad stop or timeout
//  overflow    out  1          1-clk pulse: good byte dropped, FIFO full
//  poll_tick   out  1          1-clk pulse every CLK_DIV clocks
// BEHAVIOUR
//  Reset: div/timeout counters 0, FSM IDLE, FIFO empty, sync/filter regs 1.
//   All outputs 0; rd_data 8'h00. Async assert, release sync'd by design.
//  Poll: divider counts 0..CLK_DIV-1; poll_tick=1 when count==0. All sampling,
//   edge detection and timeout counting advance only on poll_tick.
//  Sync: 2-stage shift per line on poll_tick; falling edge = prev 1, curr 0 on the
//   (filtered) clock line. Data is sampled at the edge from the same stage.
//  FSM (advances on falling edge only):
//   IDLE  : data==0 -> DATA, bitcnt=0; data==1 -> stay IDLE (ignored, no error).
//   DATA  : shift in LSB first; after 8th bit -> PARITY.
//   PARITY: latch bit; ok if ^{byte,bit}==1 (odd) -> STOP.
//   STOP  : data==1 and parity ok -> push; data==1, parity bad -> parity_err;
//           data==0 -> frame_err (takes priority over parity). Always -> IDLE.
//  Timeout: in any non-IDLE state, counter increments per poll_tick while filtered
//   ps2_clk==1; cleared on each falling edge and in IDLE. Reaching TIMEOUT ->
//   frame_err pulse, partial frame discarded, -> IDLE.
//  Latency: push/error pulse in the clk cycle after the poll_tick that detects
//   the stop edge; rd_valid rises on the following clk.
//  FIFO: FWFT, rd_data = head. Pop on rd_en & rd_valid. Push when full: byte
//   dropped, overflow pulse, contents unchanged. Push+pop same cycle:
//   both performed, count unchanged (incl. full). rd_en while empty: ignored.
//   Pointers FIFO_AW bits, wrap naturally; count = FIFO_AW+1 bits.
//  Error pulses are mutually exclusive with push in any cycle.
// CONFIGURATION
//  PS2RX_GLITCH_FILT_EN defined: each synchronised line feeds a filter whose
//   output changes only after FILT_LEN consecutive equal samples; adds FILT_LEN-1
//   poll ticks of latency. Filter regs reset to 1.
//  Undefined: filter absent, FILT_LEN unused, edge detect on 2-stage sync output.
// TESTING  (CLK_DIV=4, FIFO_AW=2, TIMEOUT=20; PS/2 bit period >= 8 poll ticks)
//  1 Frame 0x1C, parity 0, stop 1 -> rd_valid=1, rd_data=8'h1C, count=1; no errors.
//  2 Frame 0x1C, parity 1 -> parity_err one pulse; count stays 0.
//  3 Frame 0xF0, parity 1, stop 0 -> frame_err one pulse, parity_err 0; count 0.
//  4 Start + 4 bits, then ps2_clk high 25 ticks -> frame_err after 20 ticks;
//    next frame 0xF0 (parity 1) received correctly.
//  5 Bytes 0x01..0x05, no reads -> count=4, overflow once on 5th; pops give
//    01,02,03,04; then rd_valid=0. Full FIFO + rd_en on push cycle -> count stays 4.
//  6 rst_n low mid-frame after 5 bits -> outputs 0, FIFO empty; after release,
//    frame 0x5A (parity 1) -> rd_data=8'h5A. Repeat 1 with/without filter
//    macro; with it, 1-tick ps2_clk glitches inject no bits.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// Register-side bus of the PS/2 receiver: FIFO read port, status pulses and FSM state.
interface ps2_rx_fifo_if #(
    parameter int FIFO_AW = 3
) ();
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [FIFO_AW:0] fifo_count;
    logic             parity_err;
    logic             frame_err;
    logic             overflow;
    logic             poll_tick;
    logic [1:0]       dbg_state;

    // Handshake: the head byte is consumed on every clk edge where rd_en and rd_valid are
    // both 1; rd_data shows the head and is meaningful only while rd_valid is 1.
    modport slave (
        input  rd_en,
        output rd_data, rd_valid, fifo_count, parity_err, frame_err, overflow,
               poll_tick, dbg_state
    );

    modport master (
        output rd_en,
        input  rd_data, rd_valid, fifo_count, parity_err, frame_err, overflow,
               poll_tick, dbg_state
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: polled sync, frame checker with timeout, FWFT byte FIFO.
// Define PS2RX_GLITCH_FILT_EN to insert a FILT_LEN-sample glitch filter on both lines.
module ps2_rx_fifo #(
    parameter int CLK_DIV  = 64,
    parameter int TIMEOUT  = 254,
    parameter int FIFO_AW  = 3,
    parameter int FILT_LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_rx_fifo_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [DIV_W-1:0] r_div;
    logic             r_tick;

    // r_tick is registered, so it is high exactly in the cycles where r_div == 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (r_div == DIV_W'(CLK_DIV - 1)) r_div <= '0;
            else                               r_div <= r_div + 1'b1;
            r_tick <= (r_div == DIV_W'(CLK_DIV - 1));
        end
    end

    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else if (r_tick) begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    logic w_clk_line;
    logic w_dat_line;

`ifdef PS2RX_GLITCH_FILT_EN
    localparam int HW = FILT_LEN - 1;

    logic [HW-1:0] r_clk_hist;
    logic [HW-1:0] r_dat_hist;
    logic          r_clk_hold;
    logic          r_dat_hold;

    // Line follows the sync output only once it agrees with the previous FILT_LEN-1 samples
    always_comb begin
        w_clk_line = r_clk_hold;
        w_dat_line = r_dat_hold;
        if (r_clk_sync[1] && (&r_clk_hist))        w_clk_line = 1'b1;
        else if (!r_clk_sync[1] && !(|r_clk_hist)) w_clk_line = 1'b0;
        if (r_dat_sync[1] && (&r_dat_hist))        w_dat_line = 1'b1;
        else if (!r_dat_sync[1] && !(|r_dat_hist)) w_dat_line = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_hist <= '1;
            r_dat_hist <= '1;
            r_clk_hold <= 1'b1;
            r_dat_hold <= 1'b1;
        end else if (r_tick) begin
            r_clk_hist <= HW'({r_clk_hist, r_clk_sync[1]});
            r_dat_hist <= HW'({r_dat_hist, r_dat_sync[1]});
            r_clk_hold <= w_clk_line;
            r_dat_hold <= w_dat_line;
        end
    end
`else
    assign w_clk_line = r_clk_sync[1];
    assign w_dat_line = r_dat_sync[1];
`endif

    logic r_clk_prev;
    logic w_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_clk_prev <= 1'b1;
        else if (r_tick) r_clk_prev <= w_clk_line;
    end

    assign w_fall = r_tick & r_clk_prev & ~w_clk_line;

    state_t     r_state,  w_state_nx;
    logic [2:0] r_bitcnt, w_bitcnt_nx;
    logic [7:0] r_shift,  w_shift_nx;
    logic       r_par_ok, w_par_ok_nx;
    logic [7:0] r_tout,   w_tout_nx;
    logic       r_push,   w_push_nx;
    logic       r_perr,   w_perr_nx;
    logic       r_ferr,   w_ferr_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par_ok <= 1'b0;
            r_tout   <= '0;
            r_push   <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_shift  <= w_shift_nx;
            r_par_ok <= w_par_ok_nx;
            r_tout   <= w_tout_nx;
            r_push   <= w_push_nx;
            r_perr   <= w_perr_nx;
            r_ferr   <= w_ferr_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_bitcnt_nx = r_bitcnt;
        w_shift_nx  = r_shift;
        w_par_ok_nx = r_par_ok;
        w_tout_nx   = r_tout;
        w_push_nx   = 1'b0;
        w_perr_nx   = 1'b0;
        w_ferr_nx   = 1'b0;

        if (r_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_tout_nx = '0;
                    if (w_fall && !w_dat_line) begin
                        w_state_nx  = S_DATA;
                        w_bitcnt_nx = '0;
                    end
                end
                S_DATA: if (w_fall) begin
                    w_shift_nx  = {w_dat_line, r_shift[7:1]};
                    w_bitcnt_nx = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_state_nx = S_PARITY;
                end
                S_PARITY: if (w_fall) begin
                    w_par_ok_nx = ^{r_shift, w_dat_line};
                    w_state_nx  = S_STOP;
                end
                S_STOP: if (w_fall) begin
                    // A bad stop bit outranks a bad parity bit
                    if (!w_dat_line)   w_ferr_nx = 1'b1;
                    else if (r_par_ok) w_push_nx = 1'b1;
                    else               w_perr_nx = 1'b1;
                    w_state_nx = S_IDLE;
                end
                default: w_state_nx = S_IDLE;
            endcase

            if (r_state != S_IDLE) begin
                if (w_fall) begin
                    w_tout_nx = '0;
                end else if (w_clk_line) begin
                    if (r_tout == 8'(TIMEOUT - 1)) begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = S_IDLE;
                        w_tout_nx  = '0;
                    end else begin
                        w_tout_nx = r_tout + 8'd1;
                    end
                end
            end
        end
    end

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;
    logic               w_full;
    logic               w_valid;
    logic               w_pop;
    logic               w_wr;

    assign w_full  = (r_count == (FIFO_AW + 1)'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_pop   = bus.rd_en & w_valid;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign w_wr    = r_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            r_ovf <= r_push & w_full & ~w_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    assign bus.rd_data    = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.rd_valid   = w_valid;
    assign bus.fifo_count = r_count;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.overflow   = r_ovf;
    assign bus.poll_tick  = r_tick;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames, errors, timeout, FIFO overflow and reset.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
    localparam int CLK_DIV  = 4;
    localparam int TIMEOUT  = 20;
    localparam int FIFO_AW  = 2;
    localparam int FILT_LEN = 4;
    localparam int TICK     = CLK_DIV;
    localparam int HALF     = 6 * TICK;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    int checks = 0;
    int errors = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_ovf  = 0;

    ps2_rx_fifo_if #(.FIFO_AW(FIFO_AW)) bus ();

    ps2_rx_fifo #(
        .CLK_DIV (CLK_DIV),
        .TIMEOUT (TIMEOUT),
        .FIFO_AW (FIFO_AW),
        .FILT_LEN(FILT_LEN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.parity_err) n_perr++;
        if (bus.frame_err)  n_ferr++;
        if (bus.overflow)   n_ovf++;
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Sends the first n bits of a frame, LSB first; glitch adds a 1-tick low pulse per bit
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (glitch) begin
                repeat (8) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (TICK) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - 8 - TICK) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input bit glitch);
        send_bits({stp, par, b, 1'b0}, 11, glitch);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic do_pop();
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        int ticks;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b exp 0", bus.rd_valid); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.fifo_count); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h exp 00", bus.rd_data); end
        checks++; if ({bus.parity_err, bus.frame_err, bus.overflow} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {bus.parity_err, bus.frame_err, bus.overflow}); end
        checks++; if (bus.poll_tick !== 1'b0) begin errors++; $display("FAIL rst_poll_tick got %b exp 0", bus.poll_tick); end
        checks++; if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ticks = 0;
        for (int i = 0; i < 10 * CLK_DIV; i++) begin
            @(negedge clk);
            if (bus.poll_tick) ticks++;
        end
        checks++; if (ticks != 10) begin errors++; $display("FAIL poll_tick_rate got %0d exp 10", ticks); end
    endtask

    task automatic test_good_frame(input bit glitch);
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h1C, 1'b0, 1'b1, glitch);
        settle();
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL good_rd_valid g%0d got %b exp 1", glitch, bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'h1C) begin errors++; $display("FAIL good_rd_data g%0d got %h exp 1c", glitch, bus.rd_data); end
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL good_count g%0d got %0d exp 1", glitch, bus.fifo_count); end
        checks++; if ((n_perr - p0) != 0 || (n_ferr - f0) != 0) begin errors++; $display("FAIL good_no_err g%0d got perr %0d ferr %0d exp 0 0", glitch, n_perr - p0, n_ferr - f0); end
        do_pop();
        settle();
        checks++; if (bus.rd_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL good_popped got valid %b count %0d exp 0 0", bus.rd_valid, bus.fifo_count); end
    endtask

    task automatic test_parity_err();
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        settle();
        checks++; if ((n_perr - p0) != 1) begin errors++; $display("FAIL par_pulse got %0d exp 1", n_perr - p0); end
        checks++; if ((n_ferr - f0) != 0) begin errors++; $display("FAIL par_no_ferr got %0d exp 0", n_ferr - f0); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL par_count got %0d exp 0", bus.fifo_count); end
    endtask

    task automatic test_frame_err();
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        settle();
        checks++; if ((n_ferr - f0) != 1) begin errors++; $display("FAIL stop_pulse got %0d exp 1", n_ferr - f0); end
        checks++; if ((n_perr - p0) != 0) begin errors++; $display("FAIL stop_no_perr got %0d exp 0", n_perr - p0); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL stop_count got %0d exp 0", bus.fifo_count); end
    endtask

    task automatic test_timeout();
        int f0;
        f0 = n_ferr;
        send_bits({1'b1, 1'b1, 8'hF0, 1'b0}, 5, 1'b0);
        ps2_data = 1'b1;
        repeat (15 * TICK) @(negedge clk);
        #1;
        checks++; if ((n_ferr - f0) != 0) begin errors++; $display("FAIL tout_early got %0d exp 0", n_ferr - f0); end
        checks++; if (bus.dbg_state !== 2'd1) begin errors++; $display("FAIL tout_mid_state got %0d exp 1", bus.dbg_state); end
        repeat (15 * TICK) @(negedge clk);
        #1;
        checks++; if ((n_ferr - f0) != 1) begin errors++; $display("FAIL tout_pulse got %0d exp 1", n_ferr - f0); end
        checks++; if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL tout_idle got %0d exp 0", bus.dbg_state); end
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        settle();
        checks++; if (bus.rd_data !== 8'hF0 || bus.fifo_count !== 3'd1) begin errors++; $display("FAIL tout_next got %h/%0d exp f0/1", bus.rd_data, bus.fifo_count); end
        checks++; if ((n_ferr - f0) != 1) begin errors++; $display("FAIL tout_next_err got %0d exp 1", n_ferr - f0); end
        do_pop();
    endtask

    task automatic test_overflow();
        logic [7:0] vals [5];
        logic       pars [5];
        logic [7:0] rest [4];
        int o0;
        bit found;
        bit seen_stop;
        vals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        pars = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        rest = '{8'h02, 8'h03, 8'h04, 8'h06};
        o0 = n_ovf;
        for (int i = 0; i < 4; i++) begin
            send_frame(vals[i], pars[i], 1'b1, 1'b0);
            settle();
            checks++; if (bus.fifo_count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count_%0d got %0d exp %0d", i, bus.fifo_count, i + 1); end
        end
        send_frame(vals[4], pars[4], 1'b1, 1'b0);
        settle();
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", bus.fifo_count); end
        checks++; if ((n_ovf - o0) != 1) begin errors++; $display("FAIL ovf_pulse got %0d exp 1", n_ovf - o0); end
        checks++; if (bus.rd_data !== 8'h01) begin errors++; $display("FAIL ovf_head got %h exp 01", bus.rd_data); end
        found = 1'b0;
        seen_stop = 1'b0;
        fork
            send_frame(8'h06, 1'b1, 1'b1, 1'b0);
            begin
                for (int c = 0; c < 2000 && !found; c++) begin
                    @(negedge clk);
                    if (seen_stop && bus.dbg_state == 2'd0) begin
                        bus.rd_en = 1'b1;
                        found = 1'b1;
                    end else if (bus.dbg_state == 2'd3) begin
                        seen_stop = 1'b1;
                    end
                end
                @(negedge clk);
                bus.rd_en = 1'b0;
            end
        join
        settle();
        checks++; if (!found) begin errors++; $display("FAIL full_pushpop_seen got 0 exp 1"); end
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count got %0d exp 4", bus.fifo_count); end
        checks++; if ((n_ovf - o0) != 1) begin errors++; $display("FAIL full_pushpop_ovf got %0d exp 1", n_ovf - o0); end
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== rest[i]) begin errors++; $display("FAIL drain_%0d got %b/%h exp 1/%h", i, bus.rd_valid, bus.rd_data, rest[i]); end
            do_pop();
        end
        settle();
        checks++; if (bus.rd_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL drain_empty got %b/%0d exp 0/0", bus.rd_valid, bus.fifo_count); end
        do_pop();
        settle();
        checks++; if (bus.fifo_count !== 3'd0 || bus.rd_data !== 8'h00) begin errors++; $display("FAIL empty_pop got %0d/%h exp 0/00", bus.fifo_count, bus.rd_data); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, 1'b0);
        settle();
        checks++; if (bus.dbg_state !== 2'd1 || bus.fifo_count !== 3'd1) begin errors++; $display("FAIL mid_pre got %0d/%0d exp 1/1", bus.dbg_state, bus.fifo_count); end
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.rd_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.rd_data !== 8'h00) begin errors++; $display("FAIL mid_rst got %b/%0d/%h exp 0/0/00", bus.rd_valid, bus.fifo_count, bus.rd_data); end
        checks++; if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL mid_rst_state got %0d exp 0", bus.dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        settle();
        checks++; if (bus.rd_data !== 8'h5A || bus.fifo_count !== 3'd1) begin errors++; $display("FAIL mid_after got %h/%0d exp 5a/1", bus.rd_data, bus.fifo_count); end
        do_pop();
    endtask

    initial begin
        bus.rd_en = 1'b0;
        test_reset();
        test_good_frame(1'b0);
        test_parity_err();
        test_frame_err();
        test_timeout();
        test_overflow();
        test_reset_mid_frame();
`ifdef PS2RX_GLITCH_FILT_EN
        test_good_frame(1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
